// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry and coordinate helpers shared by the pixel sink.
package fb_pkg;
  localparam int WIDTH    = 160;
  localparam int HEIGHT   = 120;
  localparam int COLOR_W  = 3;
  localparam int FB_DEPTH = WIDTH * HEIGHT;
  localparam int ADDR_W   = 15;
  function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [7:0] x, input logic [6:0] y);
    return ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);
  endfunction
  function automatic logic xy_in_range(input logic [7:0] x, input logic [6:0] y);
    return (int'(x) < WIDTH) && (int'(y) < HEIGHT);
  endfunction
endpackage

// File: rtl/fb_pixel_sink_ram.sv
// fb_ram: simple dual-port framebuffer RAM, registered read that returns old data on collision.
module fb_ram
  import fb_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [COLOR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [COLOR_W-1:0] rdata
);
  logic [COLOR_W-1:0] mem [FB_DEPTH];
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end
endmodule

// File: rtl/fb_pixel_sink.sv
// fb_pixel_sink: commits plotted pixels to a shadow framebuffer with a pipelined read-back port.
module fb_pixel_sink
  import fb_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               plot_in,
  input  logic [7:0]         x_in,
  input  logic [6:0]         y_in,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               rd_req,
  input  logic [7:0]         rd_x,
  input  logic [6:0]         rd_y,
  output logic               rd_valid,
  output logic [COLOR_W-1:0] rd_color,
  output logic               rd_oob,
  output logic               oob_err,
  output logic               frame_done,
  output logic [14:0]        pix_count,
  input  logic               clr_count
);
  logic               w1_v, w1_in, w1_last, r1_v, r1_in, commit;
  logic [ADDR_W-1:0]  w1_addr, r1_addr;
  logic [COLOR_W-1:0] w1_color, ram_q;
  // reset on the commit edge must also block the RAM write of a stage-1 pixel
  assign commit = w1_v && w1_in && !reset;
  always_ff @(posedge clk) begin
    w1_addr  <= xy_to_addr(x_in, y_in);
    w1_color <= color_in;
    w1_in    <= xy_in_range(x_in, y_in);
    w1_last  <= (int'(x_in) == WIDTH - 1) && (int'(y_in) == HEIGHT - 1);
    r1_addr  <= xy_to_addr(rd_x, rd_y);
    r1_in    <= xy_in_range(rd_x, rd_y);
    if (reset) begin
      w1_v       <= 1'b0;
      r1_v       <= 1'b0;
      rd_valid   <= 1'b0;
      rd_oob     <= 1'b0;
      oob_err    <= 1'b0;
      frame_done <= 1'b0;
      pix_count  <= '0;
    end else begin
      w1_v       <= plot_in;
      r1_v       <= rd_req;
      rd_valid   <= r1_v;
      rd_oob     <= r1_v && !r1_in;
      oob_err    <= oob_err || (w1_v && !w1_in);
      frame_done <= commit && w1_last;
      pix_count  <= clr_count ? '0 :
                    (commit && pix_count != 15'(FB_DEPTH)) ? pix_count + 15'd1 : pix_count;
    end
  end
  fb_ram u_ram (
    .clk   (clk),
    .we    (commit),
    .waddr (w1_addr),
    .wdata (w1_color),
    .raddr (r1_in ? r1_addr : '0),
    .rdata (ram_q)
  );
  assign rd_color = (rd_valid && !rd_oob) ? ram_q : '0;
endmodule

// File: tb/tb_fb_pixel_sink.sv
// tb_fb_pixel_sink: directed self-checking bench for fb_pixel_sink.
module tb_fb_pixel_sink;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        plot_in = 1'b0;
  logic [7:0]  x_in = '0;
  logic [6:0]  y_in = '0;
  logic [2:0]  color_in = '0;
  logic        rd_req = 1'b0;
  logic [7:0]  rd_x = '0;
  logic [6:0]  rd_y = '0;
  logic        clr_count = 1'b0;
  logic        rd_valid, rd_oob, oob_err, frame_done;
  logic [2:0]  rd_color;
  logic [14:0] pix_count;
  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  fb_pixel_sink dut (
    .clk(clk), .reset(reset), .plot_in(plot_in), .x_in(x_in), .y_in(y_in),
    .color_in(color_in), .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y),
    .rd_valid(rd_valid), .rd_color(rd_color), .rd_oob(rd_oob), .oob_err(oob_err),
    .frame_done(frame_done), .pix_count(pix_count), .clr_count(clr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic plot(input int x, input int y, input int c);
    plot_in = 1'b1; x_in = 8'(x); y_in = 7'(y); color_in = 3'(c);
  endtask

  task automatic rd(input int x, input int y);
    rd_req = 1'b1; rd_x = 8'(x); rd_y = 7'(y);
  endtask

  task automatic idle();
    plot_in = 1'b0; rd_req = 1'b0; clr_count = 1'b0;
  endtask

  // read one location and check the response two cycles later
  task automatic read_chk(input string tag, input int x, input int y, input int c, input int oob);
    rd(x, y); tick(); idle();
    chk({tag, "_early"}, rd_valid, 0);
    tick();
    chk({tag, "_valid"}, rd_valid, 1);
    chk({tag, "_color"}, rd_color, c);
    chk({tag, "_oob"}, rd_oob, oob);
  endtask

  initial begin
    tick(); tick();
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_color", rd_color, 0);
    chk("rst_rd_oob", rd_oob, 0);
    chk("rst_oob_err", oob_err, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_pix_count", pix_count, 0);
    reset = 1'b0;

    plot(5, 7, 3); tick(); idle(); tick();
    read_chk("single", 5, 7, 3, 0);
    chk("single_count", pix_count, 1);
    chk("single_oob_err", oob_err, 0);

    plot(160, 0, 4); tick();
    plot(0, 120, 4); tick();
    plot(255, 127, 4); tick(); idle();
    chk("oob_frame_done", frame_done, 0);
    tick(); tick();
    chk("oob_count", pix_count, 1);
    chk("oob_err_set", oob_err, 1);
    read_chk("oob_read", 160, 5, 0, 1);
    chk("oob_err_sticky", oob_err, 1);

    plot(10, 10, 2); tick(); idle(); tick(); tick();
    plot(10, 10, 6); rd(10, 10); tick(); idle(); tick();
    chk("coll_valid", rd_valid, 1);
    chk("coll_old", rd_color, 2);
    rd(10, 10); tick(); idle(); tick();
    chk("coll_new", rd_color, 6);
    chk("coll_count", pix_count, 3);

    plot(1, 1, 4); tick(); idle(); tick(); tick();
    chk("pre_rst_count", pix_count, 4);
    plot(1, 1, 5); rd(3, 3); tick();
    idle(); reset = 1'b1; tick();
    reset = 1'b0;
    chk("mid_rd_valid", rd_valid, 0);
    chk("mid_rd_color", rd_color, 0);
    chk("mid_rd_oob", rd_oob, 0);
    chk("mid_oob_err", oob_err, 0);
    chk("mid_frame_done", frame_done, 0);
    chk("mid_count", pix_count, 0);
    tick();
    chk("mid_no_resp", rd_valid, 0);
    chk("mid_no_commit", pix_count, 0);
    read_chk("mid_keep", 1, 1, 4, 0);

    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++) begin
        plot(x, y, 1); tick();
        if (frame_done) fd_cnt++;
      end
    idle();
    chk("sweep_fd_n1", frame_done, 0);
    tick();
    chk("sweep_fd_n2", frame_done, 1);
    if (frame_done) fd_cnt++;
    tick();
    if (frame_done) fd_cnt++;
    chk("sweep_fd_once", fd_cnt, 1);
    chk("sweep_count", pix_count, 19200);
    for (int i = 0; i < 6; i++)
      read_chk("sweep_read", $urandom_range(159), $urandom_range(119), 1, 0);
    read_chk("sweep_corner", 159, 119, 1, 0);

    for (int i = 0; i < 5; i++) begin
      plot(i, 0, 1); tick();
    end
    idle(); tick(); tick();
    chk("sat_count", pix_count, 19200);
    plot(0, 0, 1); tick(); idle(); clr_count = 1'b1; tick(); idle();
    chk("clr_sat", pix_count, 0);
    plot(2, 2, 1); tick(); idle(); tick();
    chk("recount", pix_count, 1);
    plot(3, 3, 1); tick(); idle(); clr_count = 1'b1; tick(); idle();
    chk("clr_wins", pix_count, 0);
    tick();
    chk("clr_hold", pix_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
